// File: rtl/dmac_read_scheduler_if.sv
// Request handshake between dmac_read_scheduler (master) and the read initiator (slave).
interface dmac_read_scheduler_if #(
  parameter int ADDR_WD = 32,
  parameter int CH_WD   = 3
);
  logic               rd_req_valid;
  logic [ADDR_WD-1:0] rd_req_addr;
  logic [1:0]         rd_req_burst;
  logic [ADDR_WD-1:0] rd_req_length;
  logic [2:0]         rd_req_size;
  logic [CH_WD-1:0]   rd_req_channel;
  logic               rd_req_ack;
  logic [ADDR_WD-1:0] rd_req_next_addr;
  logic [ADDR_WD-1:0] rd_req_next_length;
  logic               rd_req_done;

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_burst, rd_req_length, rd_req_size, rd_req_channel,
    input  rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_burst, rd_req_length, rd_req_size, rd_req_channel,
    output rd_req_ack, rd_req_next_addr, rd_req_next_length, rd_req_done
  );
endinterface

// File: rtl/dmac_read_scheduler.sv
// Round-robin scheduler of per-channel DMA read requests; one outstanding request at a time.
// Optional channel abort enabled by defining DMAC_RD_SCHED_ABORT_EN.
module dmac_read_scheduler #(
  parameter int ADDR_WD       = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int CH_WD         = $clog2(CHANNEL_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNEL_COUNT-1:0]   ch_start,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_src_addr,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0] ch_length,
  input  logic [CHANNEL_COUNT*3-1:0] ch_size,
  input  logic [CHANNEL_COUNT*2-1:0] ch_burst,
`ifdef DMAC_RD_SCHED_ABORT_EN
  input  logic [CHANNEL_COUNT-1:0]   ch_abort,
`endif
  output logic [CHANNEL_COUNT-1:0]   ch_busy,
  output logic [CHANNEL_COUNT-1:0]   ch_done,
  dmac_read_scheduler_if.master      rd
);

  typedef enum logic [1:0] {IDLE, ARB, REQ} state_t;

  state_t             state_q;
  logic [ADDR_WD-1:0] addr_q  [CHANNEL_COUNT];
  logic [ADDR_WD-1:0] len_q   [CHANNEL_COUNT];
  logic [2:0]         size_q  [CHANNEL_COUNT];
  logic [1:0]         burst_q [CHANNEL_COUNT];
  logic [CHANNEL_COUNT-1:0] busy_q, done_q;
  logic [CH_WD-1:0]   rr_q, grant_q;
  logic               valid_q;
  logic [ADDR_WD-1:0] req_addr_q, req_len_q;
  logic [2:0]         req_size_q;
  logic [1:0]         req_burst_q;

  logic               found;
  logic [CH_WD-1:0]   sel;
  int unsigned        idx;
  logic               grant_abort;

  // First busy channel at or after rr_q, wrapping at CHANNEL_COUNT.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < CHANNEL_COUNT; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= CHANNEL_COUNT) idx = idx - CHANNEL_COUNT;
      if (!found && busy_q[idx]) begin
        found = 1'b1;
        sel   = CH_WD'(idx);
      end
    end
  end

`ifdef DMAC_RD_SCHED_ABORT_EN
  logic [CHANNEL_COUNT-1:0] abort_pend_q;
  always_comb grant_abort = abort_pend_q[grant_q] | ch_abort[grant_q];
`else
  always_comb grant_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= '0;
      done_q      <= '0;
      rr_q        <= '0;
      grant_q     <= '0;
      valid_q     <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_size_q  <= '0;
      req_burst_q <= '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        addr_q[i]  <= '0;
        len_q[i]   <= '0;
        size_q[i]  <= '0;
        burst_q[i] <= '0;
      end
`ifdef DMAC_RD_SCHED_ABORT_EN
      abort_pend_q <= '0;
`endif
    end else begin
      done_q <= '0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        if (ch_start[i] && !busy_q[i]) begin
          if (ch_length[i*ADDR_WD +: ADDR_WD] != '0) begin
            addr_q[i]  <= ch_src_addr[i*ADDR_WD +: ADDR_WD];
            len_q[i]   <= ch_length[i*ADDR_WD +: ADDR_WD];
            size_q[i]  <= ch_size[i*3 +: 3];
            burst_q[i] <= ch_burst[i*2 +: 2];
            busy_q[i]  <= 1'b1;
          end else begin
            done_q[i] <= 1'b1;
          end
        end
      end
`ifdef DMAC_RD_SCHED_ABORT_EN
      // A channel being granted this cycle (ARB) or already granted (REQ) is only
      // marked; it is dropped at ack so the outstanding request is never withdrawn.
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
        if (ch_abort[i] && busy_q[i]) begin
          if ((state_q == REQ && grant_q == CH_WD'(i)) ||
              (state_q == ARB && found && sel == CH_WD'(i)))
            abort_pend_q[i] <= 1'b1;
          else
            busy_q[i] <= 1'b0;
        end
      end
`endif
      case (state_q)
        IDLE: if (|busy_q) state_q <= ARB;
        ARB: begin
          if (found) begin
            grant_q     <= sel;
            req_addr_q  <= addr_q[sel];
            req_len_q   <= len_q[sel];
            req_size_q  <= size_q[sel];
            req_burst_q <= burst_q[sel];
            valid_q     <= 1'b1;
            state_q     <= REQ;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (rd.rd_req_ack) begin
            addr_q[grant_q] <= rd.rd_req_next_addr;
            len_q[grant_q]  <= rd.rd_req_next_length;
            valid_q         <= 1'b0;
            rr_q            <= (grant_q == CH_WD'(CHANNEL_COUNT - 1)) ? '0 : grant_q + 1'b1;
            state_q         <= ARB;
            if (grant_abort) begin
              busy_q[grant_q] <= 1'b0;
`ifdef DMAC_RD_SCHED_ABORT_EN
              abort_pend_q[grant_q] <= 1'b0;
`endif
            end else if (rd.rd_req_done) begin
              busy_q[grant_q] <= 1'b0;
              done_q[grant_q] <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ch_busy           = busy_q;
  assign ch_done           = done_q;
  assign rd.rd_req_valid   = valid_q;
  assign rd.rd_req_addr    = req_addr_q;
  assign rd.rd_req_length  = req_len_q;
  assign rd.rd_req_size    = req_size_q;
  assign rd.rd_req_burst   = req_burst_q;
  assign rd.rd_req_channel = grant_q;

endmodule

// File: tb/tb_dmac_read_scheduler.sv
// Directed self-checking bench for dmac_read_scheduler (abort steps run when DMAC_RD_SCHED_ABORT_EN is defined).
module tb_dmac_read_scheduler;
  localparam int AW = 32;
  localparam int CC = 8;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [CC-1:0]   ch_start;
  logic [CC*AW-1:0] ch_src_addr, ch_length;
  logic [CC*3-1:0] ch_size;
  logic [CC*2-1:0] ch_burst;
  logic [CC-1:0]   ch_busy, ch_done;
`ifdef DMAC_RD_SCHED_ABORT_EN
  logic [CC-1:0]   ch_abort;
`endif

  int checks = 0;
  int passes = 0;
  int exp_rr [3]   = '{1, 3, 6};
  int exp_wrap [4] = '{7, 0, 7, 0};

  dmac_read_scheduler_if #(.ADDR_WD(AW), .CH_WD(CW)) rd_if ();

  dmac_read_scheduler #(.ADDR_WD(AW), .CHANNEL_COUNT(CC)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_start    (ch_start),
    .ch_src_addr (ch_src_addr),
    .ch_length   (ch_length),
    .ch_size     (ch_size),
    .ch_burst    (ch_burst),
`ifdef DMAC_RD_SCHED_ABORT_EN
    .ch_abort    (ch_abort),
`endif
    .ch_busy     (ch_busy),
    .ch_done     (ch_done),
    .rd          (rd_if.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Sets channel fields and raises its start bit; caller ticks and clears ch_start.
  task automatic load(input int ch, input logic [AW-1:0] addr, input logic [AW-1:0] len);
    ch_src_addr[ch*AW +: AW] = addr;
    ch_length[ch*AW +: AW]   = len;
    ch_size[ch*3 +: 3]       = 3'((ch + 2) % 8);
    ch_burst[ch*2 +: 2]      = 2'(ch % 3);
    ch_start[ch]             = 1'b1;
  endtask

  task automatic ack_do(input logic [AW-1:0] na, input logic [AW-1:0] nl, input logic dn);
    rd_if.rd_req_ack         = 1'b1;
    rd_if.rd_req_next_addr   = na;
    rd_if.rd_req_next_length = nl;
    rd_if.rd_req_done        = dn;
    tick();
    rd_if.rd_req_ack  = 1'b0;
    rd_if.rd_req_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ch_start = '0; ch_src_addr = '0; ch_length = '0; ch_size = '0; ch_burst = '0;
`ifdef DMAC_RD_SCHED_ABORT_EN
    ch_abort = '0;
`endif
    rd_if.rd_req_ack = 1'b0; rd_if.rd_req_next_addr = '0;
    rd_if.rd_req_next_length = '0; rd_if.rd_req_done = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(rd_if.rd_req_valid), 64'd0);
    chk("rst_busy", 64'(ch_busy), 64'd0);
    chk("rst_done", 64'(ch_done), 64'd0);
    chk("rst_addr", 64'(rd_if.rd_req_addr), 64'd0);
    chk("rst_chan", 64'(rd_if.rd_req_channel), 64'd0);
    rst = 1'b0;
    tick();

    // Single channel, four bursts
    load(0, 32'h1000, 32'd256);
    tick(); ch_start = '0;
    chk("single_busy", 64'(ch_busy), 64'h01);
    chk("lat_n0_valid", 64'(rd_if.rd_req_valid), 64'd0);
    tick();
    chk("lat_n1_valid", 64'(rd_if.rd_req_valid), 64'd0);
    tick();
    chk("lat_n2_valid", 64'(rd_if.rd_req_valid), 64'd1);
    chk("req1_addr", 64'(rd_if.rd_req_addr), 64'h1000);
    chk("req1_len", 64'(rd_if.rd_req_length), 64'd256);
    chk("req1_chan", 64'(rd_if.rd_req_channel), 64'd0);
    chk("req1_size", 64'(rd_if.rd_req_size), 64'd2);
    chk("req1_burst", 64'(rd_if.rd_req_burst), 64'd0);
    tick();
    chk("stall_valid", 64'(rd_if.rd_req_valid), 64'd1);
    chk("stall_addr", 64'(rd_if.rd_req_addr), 64'h1000);
    ack_do(32'h1040, 32'd192, 1'b0);
    chk("ack_drop_valid", 64'(rd_if.rd_req_valid), 64'd0);
    tick();
    chk("req2_addr", 64'(rd_if.rd_req_addr), 64'h1040);
    chk("req2_len", 64'(rd_if.rd_req_length), 64'd192);
    load(0, 32'h9000, 32'd512);
    tick(); ch_start = '0;
    chk("restart_hold_addr", 64'(rd_if.rd_req_addr), 64'h1040);
    ack_do(32'h1080, 32'd128, 1'b0);
    tick();
    chk("req3_addr", 64'(rd_if.rd_req_addr), 64'h1080);
    chk("req3_len", 64'(rd_if.rd_req_length), 64'd128);
    ack_do(32'h10C0, 32'd64, 1'b0);
    tick();
    chk("req4_addr", 64'(rd_if.rd_req_addr), 64'h10C0);
    ack_do(32'h1100, 32'd0, 1'b1);
    chk("single_retire_busy", 64'(ch_busy), 64'h00);
    chk("single_retire_done", 64'(ch_done), 64'h01);
    tick();
    chk("done_pulse_len", 64'(ch_done), 64'h00);
    tick();
    chk("idle_valid", 64'(rd_if.rd_req_valid), 64'd0);

    // Zero length
    load(2, 32'h2000, 32'd0);
    tick(); ch_start = '0;
    chk("zero_done", 64'(ch_done), 64'h04);
    chk("zero_busy", 64'(ch_busy), 64'h00);
    tick();
    chk("zero_done_clr", 64'(ch_done), 64'h00);
    chk("zero_valid", 64'(rd_if.rd_req_valid), 64'd0);

    // Round robin 1,3,6
    load(1, 32'h0100, 32'd1000);
    load(3, 32'h0300, 32'd1000);
    load(6, 32'h0600, 32'd1000);
    tick(); ch_start = '0;
    chk("rr_busy", 64'(ch_busy), 64'h4A);
    tick(); tick();
    for (int r = 0; r < 6; r++) begin
      chk("rr_valid", 64'(rd_if.rd_req_valid), 64'd1);
      chk("rr_chan", 64'(rd_if.rd_req_channel), 64'(exp_rr[r % 3]));
      if (r < 3) chk("rr_addr", 64'(rd_if.rd_req_addr), 64'(exp_rr[r] * 256));
      ack_do(32'(exp_rr[r % 3] * 256), 32'd1000, 1'b0);
      tick();
    end
    for (int r = 0; r < 3; r++) begin
      chk("rr_ret_chan", 64'(rd_if.rd_req_channel), 64'(exp_rr[r]));
      ack_do(32'h0, 32'd100, 1'b1);
      chk("rr_ret_done", 64'(ch_done), 64'(1 << exp_rr[r]));
      tick();
    end
    chk("rr_all_retired", 64'(ch_busy), 64'h00);

    // Wrap 7,0
    load(7, 32'h7000, 32'd64);
    load(0, 32'h0800, 32'd64);
    tick(); ch_start = '0;
    tick(); tick();
    for (int r = 0; r < 4; r++) begin
      chk("wrap_chan", 64'(rd_if.rd_req_channel), 64'(exp_wrap[r]));
      ack_do(32'h0, 32'd64, 1'b0);
      tick();
    end
    chk("wrap_valid", 64'(rd_if.rd_req_valid), 64'd1);

    // Reset mid-request
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 64'(rd_if.rd_req_valid), 64'd0);
    chk("midrst_busy", 64'(ch_busy), 64'h00);
    ack_do(32'h5555, 32'd0, 1'b1);
    chk("idle_ack_busy", 64'(ch_busy), 64'h00);
    chk("idle_ack_done", 64'(ch_done), 64'h00);
    chk("idle_ack_valid", 64'(rd_if.rd_req_valid), 64'd0);

`ifdef DMAC_RD_SCHED_ABORT_EN
    load(4, 32'h4000, 32'd256);
    load(5, 32'h5000, 32'd256);
    tick(); ch_start = '0;
    tick(); tick();
    chk("abort_grant", 64'(rd_if.rd_req_channel), 64'd4);
    ch_abort = 8'h30;
    tick(); ch_abort = '0;
    chk("abort_hold_valid", 64'(rd_if.rd_req_valid), 64'd1);
    chk("abort_busy", 64'(ch_busy), 64'h10);
    tick();
    chk("abort_still_valid", 64'(rd_if.rd_req_valid), 64'd1);
    ack_do(32'h4040, 32'd192, 1'b0);
    chk("abort_ack_busy", 64'(ch_busy), 64'h00);
    chk("abort_ack_done", 64'(ch_done), 64'h00);
    tick(); tick();
    chk("abort_idle_valid", 64'(rd_if.rd_req_valid), 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
